// File: rtl/ai_recog_pkg.sv
// Shared definitions for the AI signal recognizer: waveform type codes,
// the stabilizer FSM state encoding and a small vote-count helper.
package ai_recog_pkg;

  localparam int NUM_TYPES = 5;

  localparam logic [2:0] TYPE_SINE     = 3'd0;
  localparam logic [2:0] TYPE_SQUARE   = 3'd1;
  localparam logic [2:0] TYPE_TRIANGLE = 3'd2;
  localparam logic [2:0] TYPE_SAWTOOTH = 3'd3;
  localparam logic [2:0] TYPE_NOISE    = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } stab_state_e;

  // Clamp a vote count into the 5-bit debug field (HIST_DEPTH=32 would need 6).
  function automatic logic [4:0] sat_votes5(input logic [7:0] votes);
    return (votes > 8'd31) ? 5'd31 : votes[4:0];
  endfunction

endpackage

// File: rtl/ai_vote_argmax.sv
// Combinational argmax over the per-type vote counters; the lowest type code
// wins ties because only a strictly larger count replaces the current pick.
module ai_vote_argmax
  import ai_recog_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [NUM_TYPES-1:0][CNT_W-1:0] counts_i,
  output logic [2:0]                      winner_o,
  output logic [CNT_W-1:0]                winner_cnt_o
);

  always_comb begin
    winner_o     = 3'd0;
    winner_cnt_o = counts_i[0];
    for (int i = 1; i < NUM_TYPES; i++) begin
      if (counts_i[i] > winner_cnt_o) begin
        winner_o     = 3'(i);
        winner_cnt_o = counts_i[i];
      end
    end
  end

endmodule

// File: rtl/ai_result_stabilizer.sv
// Turns the per-window classifier stream into a held, flicker-free verdict.
// Define AI_STAB_DEBUG_EN to build the reject counter and winner-vote debug port.
module ai_result_stabilizer
  import ai_recog_pkg::*;
#(
  parameter int HIST_DEPTH     = 8,
  parameter int LOCK_COUNT     = 5,
  parameter int CONF_THRESH    = 128,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ai_enable,
  input  logic [2:0] waveform_type,
  input  logic [7:0] confidence,
  input  logic       result_valid,
  output logic [2:0] stable_type,
  output logic [7:0] stable_confidence,
  output logic       locked,
  output logic       stable_valid,
  output logic       type_changed,
  output logic       result_stale,
  output logic [15:0] dbg_reject_cnt,
  output logic [4:0]  dbg_winner_votes
);

  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam int CNT_W  = FILL_W;
  localparam int SUM_W  = $clog2(HIST_DEPTH * 255 + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]        CONF_T8   = 8'(CONF_THRESH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_DEPTH);
  localparam logic [CNT_W-1:0]  LOCK_C    = CNT_W'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] hist_type_q [HIST_DEPTH];
  logic [7:0] hist_conf_q [HIST_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [FILL_W-1:0] fill_q,     fill_d;
  logic [SUM_W-1:0]  conf_sum_q, conf_sum_d;
  logic [IDLE_W-1:0] idle_q;

  stab_state_e state_q;
  logic [2:0]  stable_type_q;
  logic [7:0]  stable_conf_q;
  logic        locked_q;
  logic        stable_valid_q;
  logic        type_changed_q;
  logic        result_stale_q;
  logic        upd_q;

  logic       accept;
  logic       full;
  logic       timeout_hit;
  logic       flush;
  logic [2:0] ev_type;
  logic [7:0] ev_conf;

  logic [NUM_TYPES-1:0][CNT_W-1:0] vote_cnt;
  logic [2:0]       winner;
  logic [CNT_W-1:0] winner_cnt;
  logic [CNT_W-1:0] cur_cnt;

  assign accept = result_valid && ai_enable && (confidence >= CONF_T8)
                  && (waveform_type < 3'(NUM_TYPES));
  assign full   = (fill_q == FILL_FULL);
  // An accept in the same cycle restarts the idle window, so it beats the timeout.
  assign timeout_hit = !accept && (state_q != IDLE) && (idle_q == IDLE_LAST);
  assign flush       = !ai_enable || timeout_hit;

  // When the buffer is full the write slot holds the entry being evicted.
  assign ev_type = hist_type_q[wr_ptr_q];
  assign ev_conf = hist_conf_q[wr_ptr_q];

  always_ff @(posedge clk) begin
    if (accept) begin
      hist_type_q[wr_ptr_q] <= waveform_type;
      hist_conf_q[wr_ptr_q] <= confidence;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    conf_sum_d = conf_sum_q;
    if (flush) begin
      wr_ptr_d   = '0;
      fill_d     = '0;
      conf_sum_d = '0;
    end else if (accept) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      fill_d     = full ? fill_q : fill_q + FILL_W'(1);
      conf_sum_d = conf_sum_q + SUM_W'(confidence) - (full ? SUM_W'(ev_conf) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      conf_sum_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      conf_sum_q <= conf_sum_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TYPES; gi++) begin : g_vote
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             inc, dec;

      assign inc = accept && (waveform_type == 3'(gi));
      assign dec = accept && full && (ev_type == 3'(gi));

      always_comb begin
        cnt_d = cnt_q;
        if (flush)
          cnt_d = '0;
        else if (inc && !dec)
          cnt_d = cnt_q + CNT_W'(1);
        else if (dec && !inc)
          cnt_d = cnt_q - CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_q <= '0;
        else
          cnt_q <= cnt_d;
      end

      assign vote_cnt[gi] = cnt_q;
    end
  endgenerate

  ai_vote_argmax #(.CNT_W(CNT_W)) u_argmax (
    .counts_i     (vote_cnt),
    .winner_o     (winner),
    .winner_cnt_o (winner_cnt)
  );

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (stable_type_q == 3'(i))
        cur_cnt = vote_cnt[i];
    end
  end

  // Decision stage: sees the counters one edge after the accept that moved them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idle_q         <= '0;
      stable_type_q  <= 3'd0;
      stable_conf_q  <= 8'd0;
      locked_q       <= 1'b0;
      stable_valid_q <= 1'b0;
      type_changed_q <= 1'b0;
      result_stale_q <= 1'b0;
      upd_q          <= 1'b0;
    end else begin
      stable_valid_q <= 1'b0;
      type_changed_q <= 1'b0;
      result_stale_q <= 1'b0;
      upd_q          <= accept;
      if (flush) begin
        state_q        <= IDLE;
        idle_q         <= '0;
        stable_type_q  <= 3'd0;
        stable_conf_q  <= 8'd0;
        locked_q       <= 1'b0;
        upd_q          <= 1'b0;
        result_stale_q <= ai_enable;
      end else begin
        stable_conf_q <= 8'(conf_sum_q >> PTR_W);
        if (accept)
          idle_q <= '0;
        else if (state_q != IDLE)
          idle_q <= idle_q + IDLE_W'(1);
        case (state_q)
          IDLE: begin
            if (accept)
              state_q <= ACQUIRE;
          end
          ACQUIRE: begin
            if (upd_q && full && (winner_cnt >= LOCK_C)) begin
              state_q        <= LOCKED;
              stable_type_q  <= winner;
              locked_q       <= 1'b1;
              type_changed_q <= 1'b1;
              stable_valid_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (upd_q) begin
              stable_valid_q <= 1'b1;
              // Hysteresis: the held verdict only yields to a clear majority.
              if ((winner != stable_type_q) && (winner_cnt >= LOCK_C)
                  && (winner_cnt > cur_cnt)) begin
                stable_type_q  <= winner;
                type_changed_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign stable_type       = stable_type_q;
  assign stable_confidence = stable_conf_q;
  assign locked            = locked_q;
  assign stable_valid      = stable_valid_q;
  assign type_changed      = type_changed_q;
  assign result_stale      = result_stale_q;

`ifdef AI_STAB_DEBUG_EN
  logic [15:0] reject_cnt_q;
  logic [4:0]  winner_votes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_cnt_q   <= 16'd0;
      winner_votes_q <= 5'd0;
    end else if (flush) begin
      reject_cnt_q   <= 16'd0;
      winner_votes_q <= 5'd0;
    end else begin
      if (result_valid && !accept && (reject_cnt_q != 16'hFFFF))
        reject_cnt_q <= reject_cnt_q + 16'd1;
      winner_votes_q <= sat_votes5(8'(winner_cnt));
    end
  end

  assign dbg_reject_cnt   = reject_cnt_q;
  assign dbg_winner_votes = winner_votes_q;
`else
  assign dbg_reject_cnt   = 16'd0;
  assign dbg_winner_votes = 5'd0;
`endif

endmodule

// File: tb/tb_ai_result_stabilizer.sv
// Directed plus randomized bench for ai_result_stabilizer against a queue-based
// reference model of the accept/vote/lock/timeout rules.
module tb_ai_result_stabilizer;

  localparam int HD = 8;
  localparam int LC = 5;
  localparam int CT = 128;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ai_enable = 1'b0;
  logic [2:0] waveform_type = 3'd0;
  logic [7:0] confidence = 8'd0;
  logic       result_valid = 1'b0;
  logic [2:0] stable_type;
  logic [7:0] stable_confidence;
  logic       locked;
  logic       stable_valid;
  logic       type_changed;
  logic       result_stale;
  logic [15:0] dbg_reject_cnt;
  logic [4:0]  dbg_winner_votes;

  ai_result_stabilizer #(
    .HIST_DEPTH(HD), .LOCK_COUNT(LC), .CONF_THRESH(CT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ai_enable(ai_enable),
    .waveform_type(waveform_type), .confidence(confidence),
    .result_valid(result_valid),
    .stable_type(stable_type), .stable_confidence(stable_confidence),
    .locked(locked), .stable_valid(stable_valid), .type_changed(type_changed),
    .result_stale(result_stale), .dbg_reject_cnt(dbg_reject_cnt),
    .dbg_winner_votes(dbg_winner_votes)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  string phase = "init";

  // Reference model: the history is just the last HD accepted results.
  int     q_type[$];
  int     q_conf[$];
  int     m_type, m_conf, m_wv, m_rej;
  bit     m_locked, m_sv, m_tc, m_stale, m_prev_acc;
  longint edge_no = 0;
  longint last_acc_edge = 0;
  int     tc_seen, sv_seen, stale_seen;

  task automatic check(input string tag, input logic [15:0] obs, input int exp);
    n_cmp++;
    assert (obs === 16'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_type.delete();
    q_conf.delete();
    m_type = 0; m_conf = 0; m_wv = 0; m_rej = 0;
    m_locked = 0; m_sv = 0; m_tc = 0; m_stale = 0; m_prev_acc = 0;
  endtask

  task automatic model_edge(input bit v, input int t, input int c, input bit en);
    bit acc, tmo;
    int cnt[5];
    int sum, w, wc;
    edge_no++;
    acc = v && en && (c >= CT) && (t < 5);
    tmo = !acc && en && (q_type.size() != 0) && (edge_no - last_acc_edge == TO);
    m_sv = 0; m_tc = 0; m_stale = 0;
    if (!en || tmo) begin
      q_type.delete(); q_conf.delete();
      m_locked = 0; m_type = 0; m_conf = 0; m_wv = 0; m_rej = 0;
      m_prev_acc = 0; m_stale = tmo;
    end else begin
      cnt = '{default: 0};
      sum = 0;
      foreach (q_type[i]) begin
        cnt[q_type[i]]++;
        sum += q_conf[i];
      end
      w = 0;
      for (int k = 1; k < 5; k++) if (cnt[k] > cnt[w]) w = k;
      wc = cnt[w];
      m_conf = sum / HD;
      m_wv = wc;
      if (m_prev_acc) begin
        if (!m_locked) begin
          if (q_type.size() == HD && wc >= LC) begin
            m_locked = 1; m_type = w; m_tc = 1; m_sv = 1;
          end
        end else begin
          m_sv = 1;
          if (w != m_type && wc >= LC && wc > cnt[m_type]) begin
            m_type = w; m_tc = 1;
          end
        end
      end
      if (acc) begin
        q_type.push_back(t);
        q_conf.push_back(c);
        if (q_type.size() > HD) begin
          void'(q_type.pop_front());
          void'(q_conf.pop_front());
        end
        last_acc_edge = edge_no;
      end else if (v) begin
        if (m_rej < 65535) m_rej++;
      end
      m_prev_acc = acc;
    end
  endtask

  task automatic compare_all();
    check({phase, ".stable_type"}, 16'(stable_type), m_type);
    check({phase, ".stable_conf"}, 16'(stable_confidence), m_conf);
    check({phase, ".locked"}, 16'(locked), int'(m_locked));
    check({phase, ".stable_valid"}, 16'(stable_valid), int'(m_sv));
    check({phase, ".type_changed"}, 16'(type_changed), int'(m_tc));
    check({phase, ".result_stale"}, 16'(result_stale), int'(m_stale));
`ifdef AI_STAB_DEBUG_EN
    check({phase, ".dbg_reject"}, dbg_reject_cnt, m_rej);
    check({phase, ".dbg_votes"}, 16'(dbg_winner_votes), m_wv);
`else
    check({phase, ".dbg_reject"}, dbg_reject_cnt, 0);
    check({phase, ".dbg_votes"}, 16'(dbg_winner_votes), 0);
`endif
    tc_seen    += int'(type_changed);
    sv_seen    += int'(stable_valid);
    stale_seen += int'(result_stale);
  endtask

  task automatic cyc(input bit v, input int t, input int c, input bit en);
    result_valid  = v;
    waveform_type = 3'(t);
    confidence    = 8'(c);
    ai_enable     = en;
    @(posedge clk);
    model_edge(v, t, c, en);
    #1;
    if (v)
      $display("txn %s edge=%0d type=%0d conf=%0d en=%0d -> locked=%0d stable_type=%0d stable_conf=%0d",
               phase, edge_no, t, c, en, locked, stable_type, stable_confidence);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  task automatic pulse_reset();
    result_valid = 0;
    ai_enable = 1;
    rst_n = 0;
    #1;
    check({phase, ".rst_type"}, 16'(stable_type), 0);
    check({phase, ".rst_conf"}, 16'(stable_confidence), 0);
    check({phase, ".rst_locked"}, 16'(locked), 0);
    check({phase, ".rst_sv"}, 16'(stable_valid), 0);
    check({phase, ".rst_tc"}, 16'(type_changed), 0);
    check({phase, ".rst_stale"}, 16'(result_stale), 0);
    check({phase, ".rst_rej"}, dbg_reject_cnt, 0);
    check({phase, ".rst_votes"}, 16'(dbg_winner_votes), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int fav, t, c;
    bit v, en;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    phase = "reset";
    pulse_reset();
    idle(2);

    phase = "lock1";
    tc_seen = 0; sv_seen = 0;
    repeat (8) cyc(1, 1, 200, 1);
    idle(2);
    check("lock1.locked_final", 16'(locked), 1);
    check("lock1.type_final", 16'(stable_type), 1);
    check("lock1.conf_final", 16'(stable_confidence), 200);
    check("lock1.tc_pulses", 16'(tc_seen), 1);
    check("lock1.sv_pulses", 16'(sv_seen), 1);

    phase = "chal4";
    tc_seen = 0;
    repeat (4) cyc(1, 2, 200, 1);
    idle(2);
    check("chal4.type_held", 16'(stable_type), 1);
    check("chal4.tc_pulses", 16'(tc_seen), 0);

    phase = "chal5";
    cyc(1, 2, 200, 1);
    idle(2);
    check("chal5.type_switched", 16'(stable_type), 2);
    check("chal5.tc_pulses", 16'(tc_seen), 1);

    phase = "reject";
    cyc(1, 0, 100, 1);
    cyc(1, 6, 255, 1);
    idle(2);
`ifdef AI_STAB_DEBUG_EN
    check("reject.count", dbg_reject_cnt, 2);
`else
    check("reject.count", dbg_reject_cnt, 0);
`endif
    check("reject.type_kept", 16'(stable_type), 2);
    check("reject.locked_kept", 16'(locked), 1);

    phase = "timeout";
    stale_seen = 0;
    idle(TO);
    check("timeout.stale_pulses", 16'(stale_seen), 1);
    check("timeout.locked", 16'(locked), 0);
    check("timeout.type", 16'(stable_type), 0);

    phase = "alt";
    repeat (8) begin
      cyc(1, 0, 255, 1);
      cyc(1, 3, 255, 1);
    end
    idle(2);
    check("alt.never_locked", 16'(locked), 0);
    check("alt.conf", 16'(stable_confidence), 255);

    phase = "relock1";
    repeat (8) cyc(1, 1, 200, 1);
    idle(2);
    check("relock1.locked", 16'(locked), 1);

    phase = "reset_mid";
    pulse_reset();
    idle(1);

    phase = "relock4";
    repeat (8) cyc(1, 4, 180, 1);
    idle(2);
    check("relock4.locked", 16'(locked), 1);
    check("relock4.type", 16'(stable_type), 4);
    check("relock4.conf", 16'(stable_confidence), 180);

    phase = "flush";
    cyc(1, 4, 200, 0);
    idle(1);
    check("flush.locked", 16'(locked), 0);

    phase = "random";
    fav = $urandom_range(0, 4);
    for (int n = 0; n < 800; n++) begin
      if (n % 60 == 0) fav = $urandom_range(0, 4);
      v  = ($urandom_range(0, 9) < 7);
      t  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : fav;
      c  = $urandom_range(90, 255);
      en = ($urandom_range(0, 199) != 0);
      cyc(v, t, c, en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_result_stabilizer.md
# ai_result_stabilizer

Downstream stage of the AI signal recognizer: consumes the per-window classification stream (waveform type, confidence, valid strobe) and turns it into a stable, display-ready verdict. Low-confidence or invalid results are filtered out. Accepted results are majority-voted over a sliding history, and the verdict is held with hysteresis so the UI does not flicker. A verdict with no fresh accepted result for too long is declared stale.

## Interface
- HIST_DEPTH, 8: voting history length; power of 2, 4..32
- LOCK_COUNT, 5: votes one type needs to lock or to take over; ≤ HIST_DEPTH
- CONF_THRESH, 128: minimum confidence for a result to be accepted
- TIMEOUT_CYCLES, 50_000_000: idle cycles before the verdict is dropped; counter width is $clog2(TIMEOUT_CYCLES+1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ai_enable  in  1  when low, synchronous flush to IDLE, one cycle after low is sampled
- waveform_type  in  3  classifier type code
- confidence  in  8  classifier confidence
- result_valid  in  1  one-cycle strobe qualifying type and confidence
- stable_type  out  3  held verdict
- stable_confidence  out  8  mean confidence of the history
- locked  out  1  verdict valid
- stable_valid  out  1  pulse on every decision update while locked
- type_changed  out  1  pulse when stable_type changes or locked rises
- result_stale  out  1  pulse on timeout
- dbg_reject_cnt  out  16  rejected-result count (see Configuration)
- dbg_winner_votes  out  5  current winner's vote count (see Configuration)

## Operation
- Accept condition: result_valid && ai_enable && confidence ≥ CONF_THRESH && waveform_type < NUM_TYPES (5). Every other strobe is rejected and changes no state.
- History is a circular buffer of {type, confidence} with a write pointer and a fill count that saturates at HIST_DEPTH.
- Vote counters: one per type.
  - On accept, increment the new type's counter.
  - If the buffer is full, also decrement the evicted entry's type counter.
  - If the new and evicted types are equal, the counter is unchanged.
- conf_sum is maintained the same way (add new, subtract evicted) and is HIST_DEPTH·255-wide, no overflow. stable_confidence = conf_sum >> log2(HIST_DEPTH).
- Argmax over the counters picks the highest count; on a tie the lowest type code wins.
- FSM states:
  - IDLE, fill = 0: first accept → ACQUIRE.
  - ACQUIRE: when fill == HIST_DEPTH and winner count ≥ LOCK_COUNT → LOCKED. stable_type ← winner, locked ← 1, type_changed pulse.
  - LOCKED: stable_type changes only when a challenger has count ≥ LOCK_COUNT and strictly more votes than the current stable_type. On a change, type_changed pulses. Otherwise the old verdict is held even if its count falls below LOCK_COUNT (hysteresis).
- Timeout: the idle counter resets on every accept and increments otherwise in ACQUIRE or LOCKED. On reaching TIMEOUT_CYCLES:
  - flush history, counters and sum
  - locked ← 0, stable_type and stable_confidence ← 0
  - result_stale pulses, FSM → IDLE
- ai_enable low: same flush, but result_stale does not pulse.
- Reset values: every output 0, FSM IDLE, pointers 0, all counters 0.

## Timing
- Accept sampled at edge E: history, counters and sum update at E.
- Decision register updates at E+1, so stable_* / locked / stable_valid / type_changed appear 2 cycles after the result_valid strobe is presented.
- Back-to-back accepts, one per cycle, are fully supported; no stalls and no drops.
- A timeout and an accept in the same cycle: the accept wins and the timeout is suppressed.
- ai_enable falling in the same cycle as an accept: the flush wins and the result is dropped.
- Reset asserted mid-operation clears everything immediately (asynchronous); outputs are 0 until 2 cycles after the first accept following release.

## Configuration
- AI_STAB_DEBUG_EN defined:
  - dbg_reject_cnt counts rejected strobes, saturating at 0xFFFF, cleared by reset or flush.
  - dbg_winner_votes shows the argmax count.
- Undefined: the counter logic is not compiled and both debug ports are tied to 0.

## Structure
- Shared package ai_recog_pkg holds:
  - type codes TYPE_SINE=0, TYPE_SQUARE=1, TYPE_TRIANGLE=2, TYPE_SAWTOOTH=3, TYPE_NOISE=4
  - NUM_TYPES=5
  - the FSM state enum (IDLE/ACQUIRE/LOCKED)
  
  The classifier uses the same package.
- One sub-module, ai_vote_argmax: combinational argmax over NUM_TYPES counters with lowest-index tie-break; outputs winner index and count.

## Test plan
Defaults unless noted: HIST_DEPTH=8, LOCK_COUNT=5, CONF_THRESH=128.
- 8 back-to-back type 1 strobes at conf 200 → 2 cycles after the 8th: locked=1, stable_type=1, stable_confidence=200, type_changed and stable_valid pulse once.
- Locked on type 1, then 5 type 2 strobes at conf 200 → counts 1:3 / 2:5. type_changed pulses after the 5th; stable_type=2. After only 4 strobes (1:4 / 2:4), stable_type stays 1.
- Strobes at conf 100 and strobe with type 6, conf 255 → no state change; dbg_reject_cnt=2 with AI_STAB_DEBUG_EN, 0 without.
- Locked, TIMEOUT_CYCLES=1000, no strobes → at cycle 1000 after the last accept: result_stale pulses, locked=0, stable_type=0, FSM IDLE.
- Alternating types 0/3 at conf 255 for 16 strobes → counts 4/4, never locks, stays ACQUIRE.
- rst_n low for 1 cycle while locked → all outputs 0 that cycle; after release, 8 type 4 strobes relock on type 4.
